rcu_bus_cond_detect: RTL and testbench

- Oversampled, parametrised successor of the asynchronous START-flag detector on the RCU→FEE/TRU serial link.
- Samples rcu_scl/rcu_sda_in on the board system clock, synchronises and glitch-filters both lines, and detects START, repeated START and STOP conditions.
- Also provides SCL edge strobes, a bus-busy flag, a stuck-SCL timeout and a legacy start_flag level.
- Sits between the RCU pins and the rcui2c_fsm; everything downstream runs single-clock.

---
 rtl/rcu_bus_cond_detect.sv | 163 ++++++++++++++++
 tb/tb_rcu_bus_cond_detect.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcu_bus_cond_detect.sv
// rcu_bus_cond_detect: oversampled START / repeated START / STOP detector for
// the RCU serial link. Synchronises and glitch-filters SCL/SDA on clk, then
// decodes bus conditions, SCL edge strobes, bus-busy and a stuck-SCL timeout.
module rcu_bus_cond_detect #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 3,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic det_en,
  input  logic rcu_scl,
  input  logic rcu_sda_in,
  output logic scl_filt,
  output logic sda_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_pulse,
  output logic rep_start_pulse,
  output logic stop_pulse,
  output logic start_flag,
  output logic bus_busy,
  output logic timeout_pulse
);

  localparam int unsigned FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FCNT_W-1:0]    FCNT_MAX = FCNT_W'(FILTER_LEN - 1);
  localparam logic [TIMEOUT_W-1:0] TO_MAX   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_synced_c;
  logic                   sda_synced_c;
  logic [FCNT_W-1:0]      scl_cnt;
  logic [FCNT_W-1:0]      sda_cnt;
  logic                   scl_prev;
  logic                   sda_prev;
  logic [TIMEOUT_W-1:0]   to_cnt;
  logic [TIMEOUT_W-1:0]   to_cnt_n;

  logic scl_rise_c;
  logic scl_fall_c;
  logic start_c;
  logic stop_c;
  logic to_fire_c;
  logic busy_n;
  logic flag_n;

  assign scl_synced_c = scl_sync[SYNC_STAGES-1];
  assign sda_synced_c = sda_sync[SYNC_STAGES-1];

  // Plain shift-register synchronisers; idle bus level after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], rcu_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], rcu_sda_in};
    end
  end

  // SCL filter: follow the synced line only after FILTER_LEN differing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_filt <= 1'b1;
      scl_cnt  <= '0;
    end else if (scl_synced_c == scl_filt) begin
      scl_cnt  <= '0;
    end else if (scl_cnt == FCNT_MAX) begin
      scl_filt <= scl_synced_c;
      scl_cnt  <= '0;
    end else begin
      scl_cnt  <= scl_cnt + FCNT_W'(1);
    end
  end

  // SDA filter: same rule as SCL.
  always_ff @(posedge clk) begin
    if (reset) begin
      sda_filt <= 1'b1;
      sda_cnt  <= '0;
    end else if (sda_synced_c == sda_filt) begin
      sda_cnt  <= '0;
    end else if (sda_cnt == FCNT_MAX) begin
      sda_filt <= sda_synced_c;
      sda_cnt  <= '0;
    end else begin
      sda_cnt  <= sda_cnt + FCNT_W'(1);
    end
  end

  // Edge and condition decode; a simultaneous SCL change suppresses decode
  // because scl_prev then differs from scl_filt.
  assign scl_rise_c = scl_filt & ~scl_prev;
  assign scl_fall_c = ~scl_filt & scl_prev;
  assign start_c    = det_en & scl_filt & scl_prev & ~sda_filt & sda_prev;
  assign stop_c     = det_en & scl_filt & scl_prev & sda_filt & ~sda_prev;

  // Next-state for bus_busy, start_flag and the SCL-low timeout counter.
  always_comb begin
    busy_n    = bus_busy;
    flag_n    = start_flag;
    to_cnt_n  = to_cnt;
    to_fire_c = 1'b0;
    if (!det_en) begin
      busy_n   = 1'b0;
      flag_n   = 1'b0;
      to_cnt_n = '0;
    end else begin
      if (!bus_busy || scl_filt) begin
        to_cnt_n = '0;
      end else if (to_cnt == TO_MAX) begin
        to_fire_c = 1'b1;
      end else begin
        to_cnt_n = to_cnt + TIMEOUT_W'(1);
      end

      if (start_c) begin
        busy_n = 1'b1;
      end else if (stop_c || to_fire_c) begin
        busy_n = 1'b0;
      end

      if (start_c) begin
        flag_n = 1'b1;
      end else if (scl_fall_c) begin
        flag_n = 1'b0;
      end
    end
  end

  // Registered strobes, previous-cycle line copies and bus state.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_prev        <= 1'b1;
      sda_prev        <= 1'b1;
      scl_rise        <= 1'b0;
      scl_fall        <= 1'b0;
      start_pulse     <= 1'b0;
      rep_start_pulse <= 1'b0;
      stop_pulse      <= 1'b0;
      timeout_pulse   <= 1'b0;
      start_flag      <= 1'b0;
      bus_busy        <= 1'b0;
      to_cnt          <= '0;
    end else begin
      scl_prev        <= scl_filt;
      sda_prev        <= sda_filt;
      scl_rise        <= scl_rise_c;
      scl_fall        <= scl_fall_c;
      start_pulse     <= start_c;
      rep_start_pulse <= start_c & bus_busy;
      stop_pulse      <= stop_c;
      timeout_pulse   <= to_fire_c;
      start_flag      <= flag_n;
      bus_busy        <= busy_n;
      to_cnt          <= to_cnt_n;
    end
  end

endmodule

// File: tb/tb_rcu_bus_cond_detect.sv
// Bench for rcu_bus_cond_detect: directed scenarios with literal expectations
// plus randomized pins, all checked every cycle against a behavioural model.
module tb_rcu_bus_cond_detect;

  localparam int unsigned SS = 2;
  localparam int unsigned FL = 3;
  localparam int unsigned TC = 1000;

  logic clk = 1'b0;
  logic reset, det_en, rcu_scl, rcu_sda_in;
  logic scl_filt, sda_filt, scl_rise, scl_fall, start_pulse, rep_start_pulse;
  logic stop_pulse, start_flag, bus_busy, timeout_pulse;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  rcu_bus_cond_detect #(
    .SYNC_STAGES(SS), .FILTER_LEN(FL), .TIMEOUT_W(16), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .reset(reset), .det_en(det_en), .rcu_scl(rcu_scl), .rcu_sda_in(rcu_sda_in),
    .scl_filt(scl_filt), .sda_filt(sda_filt), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_pulse(start_pulse), .rep_start_pulse(rep_start_pulse), .stop_pulse(stop_pulse),
    .start_flag(start_flag), .bus_busy(bus_busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit scl_pipe[$], sda_pipe[$];   // raw samples still in flight through the synchroniser
  bit scl_win[$], sda_win[$];     // last FL synchronised samples
  bit m_scl_filt, m_sda_filt, m_scl_prev, m_sda_prev;
  bit m_rise, m_fall, m_start, m_rep, m_stop, m_flag, m_busy, m_to;
  int low_run;

  task automatic model_reset();
    scl_pipe.delete(); sda_pipe.delete(); scl_win.delete(); sda_win.delete();
    for (int i = 0; i < SS; i++) begin scl_pipe.push_back(1'b1); sda_pipe.push_back(1'b1); end
    for (int i = 0; i < FL; i++) begin scl_win.push_back(1'b1); sda_win.push_back(1'b1); end
    m_scl_filt = 1; m_sda_filt = 1; m_scl_prev = 1; m_sda_prev = 1;
    m_rise = 0; m_fall = 0; m_start = 0; m_rep = 0; m_stop = 0; m_flag = 0; m_busy = 0; m_to = 0;
    low_run = 0;
  endtask

  always @(posedge clk) begin : model_blk
    bit s_scl, s_sda, nf_scl, nf_sda, st, sp, ri, fa, to;
    int nd_scl, nd_sda;
    if (reset) begin
      model_reset();
    end else begin
      s_scl = scl_pipe.pop_front(); scl_pipe.push_back(rcu_scl);
      s_sda = sda_pipe.pop_front(); sda_pipe.push_back(rcu_sda_in);
      void'(scl_win.pop_front()); scl_win.push_back(s_scl);
      void'(sda_win.pop_front()); sda_win.push_back(s_sda);
      nd_scl = 0; nd_sda = 0;
      foreach (scl_win[i]) if (scl_win[i] != m_scl_filt) nd_scl++;
      foreach (sda_win[i]) if (sda_win[i] != m_sda_filt) nd_sda++;
      nf_scl = (nd_scl == FL) ? s_scl : m_scl_filt;
      nf_sda = (nd_sda == FL) ? s_sda : m_sda_filt;
      // conditions: SDA edge while SCL has been high for two samples
      st = det_en && m_scl_filt && m_scl_prev && !m_sda_filt && m_sda_prev;
      sp = det_en && m_scl_filt && m_scl_prev && m_sda_filt && !m_sda_prev;
      ri = m_scl_filt && !m_scl_prev;
      fa = !m_scl_filt && m_scl_prev;
      to = 0;
      if (det_en && m_busy && !m_scl_filt) begin
        low_run++;
        to = (low_run == TC);
      end else begin
        low_run = 0;
      end
      m_rep = st && m_busy;
      if (!det_en) m_busy = 0;
      else if (st) m_busy = 1;
      else if (sp || to) m_busy = 0;
      if (!det_en) m_flag = 0;
      else if (st) m_flag = 1;
      else if (fa) m_flag = 0;
      m_scl_prev = m_scl_filt; m_sda_prev = m_sda_filt;
      m_scl_filt = nf_scl;     m_sda_filt = nf_sda;
      m_rise = ri; m_fall = fa; m_start = st; m_stop = sp; m_to = to;
    end
  end

  // ---------------- checking ----------------
  task automatic cmp(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("scl_filt", scl_filt, m_scl_filt);
      cmp("sda_filt", sda_filt, m_sda_filt);
      cmp("scl_rise", scl_rise, m_rise);
      cmp("scl_fall", scl_fall, m_fall);
      cmp("start_pulse", start_pulse, m_start);
      cmp("rep_start_pulse", rep_start_pulse, m_rep);
      cmp("stop_pulse", stop_pulse, m_stop);
      cmp("start_flag", start_flag, m_flag);
      cmp("bus_busy", bus_busy, m_busy);
      cmp("timeout_pulse", timeout_pulse, m_to);
    end
  end

  // ---------------- stimulus helpers ----------------
  int n_rise, n_fall, n_start, n_rep, n_stop, n_to;
  bit saw_sda_low, saw_busy;

  task automatic clr_counts();
    n_rise = 0; n_fall = 0; n_start = 0; n_rep = 0; n_stop = 0; n_to = 0;
    saw_sda_low = 0; saw_busy = 0;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      n_rise  += int'(scl_rise === 1'b1);
      n_fall  += int'(scl_fall === 1'b1);
      n_start += int'(start_pulse === 1'b1);
      n_rep   += int'(rep_start_pulse === 1'b1);
      n_stop  += int'(stop_pulse === 1'b1);
      n_to    += int'(timeout_pulse === 1'b1);
      if (sda_filt === 1'b0) saw_sda_low = 1;
      if (bus_busy === 1'b1) saw_busy = 1;
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return start_pulse;
      1:       return stop_pulse;
      default: return timeout_pulse;
    endcase
  endfunction

  // Cycles from now until the selected strobe is seen; -1 if never within limit.
  task automatic wait_sig(input int sel, input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc(1);
      if (sig(sel) === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic pins(input bit scl, input bit sda);
    rcu_scl = scl; rcu_sda_in = sda;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1; det_en = 1; pins(1, 1);
    clr_counts();
    cyc(3);
    chk_on = 1;
    reset = 0;
    cyc(2);
    check_int("reset_scl_filt", int'(scl_filt), 1);
    check_int("reset_sda_filt", int'(sda_filt), 1);
    check_int("reset_bus_busy", int'(bus_busy), 0);
    check_int("reset_start_flag", int'(start_flag), 0);

    // START latency and flags
    pins(1, 0);
    wait_sig(0, 20, lat);
    check_int("start_latency", lat, 6);
    check_int("start_busy", int'(bus_busy), 1);
    check_int("start_flag_set", int'(start_flag), 1);
    check_int("start_not_rep", int'(rep_start_pulse), 0);
    cyc(4);

    // 8 SCL pulses then STOP
    clr_counts();
    for (int k = 0; k < 8; k++) begin
      pins(0, 0); cyc(20);
      if (k == 0) check_int("start_flag_cleared", int'(start_flag), 0);
      pins(1, 0); cyc(20);
    end
    pins(1, 1);
    wait_sig(1, 20, lat);
    check_int("stop_latency", lat, 6);
    cyc(1);
    check_int("stop_busy_clear", int'(bus_busy), 0);
    check_int("byte_rises", n_rise, 8);
    check_int("byte_falls", n_fall, 8);
    check_int("byte_stops", n_stop, 1);
    cyc(5);

    // repeated START
    clr_counts();
    pins(1, 0); cyc(10);
    pins(0, 0); cyc(10);
    pins(0, 1); cyc(10);
    pins(1, 1); cyc(10);
    pins(1, 0); cyc(10);
    check_int("rep_starts", n_start, 2);
    check_int("rep_rep", n_rep, 1);
    check_int("rep_busy", int'(bus_busy), 1);
    pins(1, 1); cyc(10);
    check_int("rep_stop_busy", int'(bus_busy), 0);

    // glitch rejection, then minimal accepted low
    clr_counts();
    pins(1, 0); cyc(2);
    pins(1, 1); cyc(15);
    check_int("glitch_starts", n_start, 0);
    check_int("glitch_sda_low", int'(saw_sda_low), 0);
    pins(1, 0); cyc(3);
    pins(1, 1); cyc(15);
    check_int("min_low_starts", n_start, 1);
    check_int("min_low_stops", n_stop, 1);

    // SCL stuck low timeout
    clr_counts();
    pins(1, 0); cyc(10);
    pins(0, 0); cyc(1100);
    check_int("timeout_count", n_to, 1);
    check_int("timeout_busy", int'(bus_busy), 0);
    saw_busy = 0;
    pins(1, 0); cyc(20);
    pins(1, 1); cyc(15);
    check_int("post_to_stops", n_stop, 1);
    check_int("post_to_busy", int'(saw_busy), 0);

    // detection disabled during START, re-enabled mid-byte
    clr_counts();
    det_en = 0;
    pins(1, 0); cyc(10);
    pins(0, 0); cyc(10);
    det_en = 1;
    for (int k = 0; k < 3; k++) begin
      pins(1, 0); cyc(10);
      pins(0, 0); cyc(10);
    end
    check_int("dis_starts", n_start, 0);
    check_int("dis_busy", int'(saw_busy), 0);
    check_int("dis_rises", n_rise, 3);
    check_int("dis_falls", n_fall, 4);
    pins(0, 1); cyc(10);
    pins(1, 1); cyc(10);

    // reset mid-transaction
    pins(1, 0); cyc(10);
    pins(0, 0); cyc(10);
    check_int("pre_reset_busy", int'(bus_busy), 1);
    reset = 1; cyc(1);
    check_int("rst_scl_filt", int'(scl_filt), 1);
    check_int("rst_sda_filt", int'(sda_filt), 1);
    check_int("rst_busy", int'(bus_busy), 0);
    check_int("rst_flag", int'(start_flag), 0);
    check_int("rst_fall", int'(scl_fall), 0);
    reset = 0;
    clr_counts();
    cyc(10);
    check_int("post_rst_busy", int'(saw_busy), 0);
    pins(1, 0); cyc(10);
    pins(1, 1); cyc(10);

    // randomized pins, enable and occasional reset
    for (int it = 0; it < 1500; it++) begin
      pins(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      det_en = ($urandom_range(0, 15) != 0);
      reset  = ($urandom_range(0, 200) == 0);
      if (reset) begin
        cyc(1);
        reset = 0;
      end
      cyc(int'($urandom_range(1, 25)));
    end
    pins(1, 1); det_en = 1; cyc(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
